cpu_control_unit: RTL and testbench

- Instruction sequencer that drives every control input of data_path; the datapath is the responder, this block is the initiator.
- Fetches a 16-bit instruction into IR and any operand bytes from external memory over the shared 8-bit data_bus.
- Decodes ir_value and issues per-cycle register, ALU, MAR, JR and PC strobes.
- Sits between data_path and the memory controller.

---
 rtl/cpu_control_unit.sv | 177 +++++++++++++++++
 tb/tb_cpu_control_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: fetch/decode/execute sequencer driving data_path and memory strobes.
// Define CU_STEP_EN to add single-step control (step in, at_boundary out).
module cpu_control_unit #(
  parameter int OPC_W = 4,
  parameter int REG_SEL_W = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [15:0]          ir_value,
  input  logic [2:0]           flags,
  input  logic                 mem_ready,
`ifdef CU_STEP_EN
  input  logic                 step,
  output logic                 at_boundary,
`endif
  output logic                 gp_write,
  output logic                 gp_read,
  output logic [REG_SEL_W-1:0] gp_input_select,
  output logic [REG_SEL_W-1:0] gp_output_select,
  output logic [REG_SEL_W-1:0] gp_alu_output_select,
  output logic [3:0]           alu_operation,
  output logic                 latch_alu,
  output logic                 alu_store_high,
  output logic                 alu_store_low,
  output logic                 mar_load_high,
  output logic                 mar_load_low,
  output logic                 ir_load_high,
  output logic                 ir_load_low,
  output logic                 jr_load_high,
  output logic                 jr_load_low,
  output logic                 pc_increment,
  output logic                 pc_set,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 mem_addr_sel,
  output logic                 halted
);
  typedef enum logic [3:0] {
    S_FETCH_HI, S_FETCH_LO, S_DECODE, S_EXEC_MOV, S_EXEC_ALU, S_IMM, S_WB,
    S_ADDR_HI, S_ADDR_LO, S_MEM_RD, S_MEM_WR, S_JUMP, S_HALT
  } state_t;
  localparam logic [OPC_W-1:0] OP_MOV  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_ALU  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_ALUI = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_JZ   = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(15);
  state_t state_q, state_d;
  logic [OPC_W-1:0] opc;
  logic [REG_SEL_W-1:0] rd, rs;
  logic [3:0] aluop;
  logic jmp, go, unused_bits;
  assign opc = ir_value[15 -: OPC_W];
  assign rd = ir_value[11 -: REG_SEL_W];
  assign rs = ir_value[8 -: REG_SEL_W];
  assign aluop = ir_value[3:0];
  assign jmp = opc == OP_JMP || opc == OP_JZ;
  assign unused_bits = ^{ir_value[5:4], flags[2:1]};
`ifdef CU_STEP_EN
  assign go = step;
  assign at_boundary = reset && state_q == S_FETCH_HI && !step;
`else
  assign go = 1'b1;
`endif
  // Outputs are forced low while reset is held, independent of the decoded state.
  always_comb begin
    state_d = state_q;
    {gp_write, gp_read, latch_alu, alu_store_high, alu_store_low, mar_load_high, mar_load_low,
     ir_load_high, ir_load_low, jr_load_high, jr_load_low, pc_increment, pc_set,
     mem_read, mem_write, mem_addr_sel, halted} = '0;
    gp_input_select = '0;
    gp_output_select = '0;
    gp_alu_output_select = '0;
    alu_operation = '0;
    if (reset) begin
      case (state_q)
        S_FETCH_HI: begin
          mem_read = go;
          ir_load_high = go && mem_ready;
          pc_increment = go && mem_ready;
          state_d = (go && mem_ready) ? S_FETCH_LO : S_FETCH_HI;
        end
        S_FETCH_LO: begin
          mem_read = 1'b1;
          ir_load_low = mem_ready;
          pc_increment = mem_ready;
          state_d = mem_ready ? S_DECODE : S_FETCH_LO;
        end
        S_DECODE: begin
          case (opc)
            OP_MOV: state_d = S_EXEC_MOV;
            OP_ALU: state_d = S_EXEC_ALU;
            OP_LDI, OP_ALUI: state_d = S_IMM;
            OP_LD, OP_ST, OP_JMP, OP_JZ: state_d = S_ADDR_HI;
            OP_HALT: state_d = S_HALT;
            default: state_d = S_FETCH_HI;
          endcase
        end
        S_EXEC_MOV: begin
          gp_output_select = rs;
          gp_write = 1'b1;
          gp_input_select = rd;
          gp_read = 1'b1;
          state_d = S_FETCH_HI;
        end
        S_EXEC_ALU: begin
          gp_alu_output_select = rd;
          gp_output_select = rs;
          gp_write = 1'b1;
          alu_operation = aluop;
          latch_alu = 1'b1;
          state_d = S_WB;
        end
        S_IMM: begin
          mem_read = 1'b1;
          pc_increment = mem_ready;
          if (mem_ready && opc == OP_LDI) begin
            gp_input_select = rd;
            gp_read = 1'b1;
            state_d = S_FETCH_HI;
          end else if (mem_ready) begin
            gp_alu_output_select = rd;
            alu_operation = aluop;
            latch_alu = 1'b1;
            state_d = S_WB;
          end
        end
        S_WB: begin
          alu_store_low = 1'b1;
          gp_input_select = rd;
          gp_read = 1'b1;
          state_d = S_FETCH_HI;
        end
        S_ADDR_HI: begin
          mem_read = 1'b1;
          pc_increment = mem_ready;
          jr_load_high = mem_ready && jmp;
          mar_load_high = mem_ready && !jmp;
          state_d = mem_ready ? S_ADDR_LO : S_ADDR_HI;
        end
        S_ADDR_LO: begin
          mem_read = 1'b1;
          pc_increment = mem_ready;
          jr_load_low = mem_ready && jmp;
          mar_load_low = mem_ready && !jmp;
          if (mem_ready) state_d = jmp ? S_JUMP : (opc == OP_ST ? S_MEM_WR : S_MEM_RD);
        end
        S_MEM_RD: begin
          mem_addr_sel = 1'b1;
          mem_read = 1'b1;
          gp_input_select = mem_ready ? rd : '0;
          gp_read = mem_ready;
          state_d = mem_ready ? S_FETCH_HI : S_MEM_RD;
        end
        S_MEM_WR: begin
          mem_addr_sel = 1'b1;
          mem_write = 1'b1;
          gp_output_select = rs;
          gp_write = 1'b1;
          state_d = mem_ready ? S_FETCH_HI : S_MEM_WR;
        end
        S_JUMP: begin
          pc_set = opc == OP_JMP || flags[0];
          state_d = S_FETCH_HI;
        end
        S_HALT: halted = 1'b1;
        default: state_d = S_FETCH_HI;
      endcase
    end
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) state_q <= S_FETCH_HI;
    else state_q <= state_d;
endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: runs a directed program through the sequencer and checks every cycle
// against an instruction-level expectation list; a small datapath/memory model feeds ir_value.
module tb_cpu_control_unit;
  typedef struct packed {
    logic gp_write, gp_read;
    logic [2:0] gp_in, gp_out, gp_alu;
    logic [3:0] alu_op;
    logic latch_alu, alu_hi, alu_lo, mar_hi, mar_lo, ir_hi, ir_lo, jr_hi, jr_lo;
    logic pc_inc, pc_set, mem_rd, mem_wr, addr_sel, halted;
  } outs_t;
  typedef struct {
    logic rst_n;
    logic ready;
    logic [2:0] fl;
    int tag;
    outs_t exp;
  } ent_t;
  logic clock, reset, mem_ready;
  logic [15:0] ir_value;
  logic [2:0] flags;
  logic gp_write, gp_read, latch_alu, alu_store_high, alu_store_low;
  logic [2:0] gp_input_select, gp_output_select, gp_alu_output_select;
  logic [3:0] alu_operation;
  logic mar_load_high, mar_load_low, ir_load_high, ir_load_low, jr_load_high, jr_load_low;
  logic pc_increment, pc_set, mem_read, mem_write, mem_addr_sel, halted;
`ifdef CU_STEP_EN
  logic at_boundary;
`endif
  cpu_control_unit dut (
    .clock(clock), .reset(reset), .ir_value(ir_value), .flags(flags), .mem_ready(mem_ready),
`ifdef CU_STEP_EN
    .step(1'b1), .at_boundary(at_boundary),
`endif
    .gp_write(gp_write), .gp_read(gp_read), .gp_input_select(gp_input_select),
    .gp_output_select(gp_output_select), .gp_alu_output_select(gp_alu_output_select),
    .alu_operation(alu_operation), .latch_alu(latch_alu), .alu_store_high(alu_store_high),
    .alu_store_low(alu_store_low), .mar_load_high(mar_load_high), .mar_load_low(mar_load_low),
    .ir_load_high(ir_load_high), .ir_load_low(ir_load_low), .jr_load_high(jr_load_high),
    .jr_load_low(jr_load_low), .pc_increment(pc_increment), .pc_set(pc_set),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr_sel(mem_addr_sel), .halted(halted)
  );
  outs_t act;
  assign act = {gp_write, gp_read, gp_input_select, gp_output_select, gp_alu_output_select,
                alu_operation, latch_alu, alu_store_high, alu_store_low, mar_load_high,
                mar_load_low, ir_load_high, ir_load_low, jr_load_high, jr_load_low,
                pc_increment, pc_set, mem_read, mem_write, mem_addr_sel, halted};
  logic [7:0] mem [0:65535];
  logic [15:0] pc, ir, mar, jr;
  ent_t q[$];
  logic [2:0] cur_fl;
  int tests = 0, fails = 0, pcinc = 0;
  initial clock = 1'b0;
  always #5 clock = ~clock;
  // Datapath stand-in: byte loads come from memory at the current PC, as the real datapath would.
  always @(posedge clock or negedge reset)
    if (!reset) begin
      pc <= '0; ir <= '0; mar <= '0; jr <= '0;
    end else begin
      if (ir_load_high) ir[15:8] <= mem[pc];
      if (ir_load_low) ir[7:0] <= mem[pc];
      if (mar_load_high) mar[15:8] <= mem[pc];
      if (mar_load_low) mar[7:0] <= mem[pc];
      if (jr_load_high) jr[15:8] <= mem[pc];
      if (jr_load_low) jr[7:0] <= mem[pc];
      if (pc_set) pc <= jr;
      else if (pc_increment) pc <= pc + 16'd1;
    end
  assign ir_value = ir;
  task automatic chk(input string nm, input int a, input int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, a, e);
    end
  endtask
  task automatic put16(input int a, input logic [15:0] w);
    mem[a] = w[15:8];
    mem[a+1] = w[7:0];
  endtask
  task automatic mphase(input int st, input outs_t h, input outs_t s);
    repeat (st) q.push_back('{1'b1, 1'b0, cur_fl, 0, h});
    q.push_back('{1'b1, 1'b1, cur_fl, 0, s});
  endtask
  task automatic iphase(input outs_t o);
    q.push_back('{1'b1, 1'($urandom_range(0, 1)), cur_fl, 0, o});
  endtask
  task automatic rst(input int n);
    outs_t z;
    z = '0;
    repeat (n) q.push_back('{1'b0, 1'b0, 3'b000, 0, z});
  endtask
  task automatic wb(input logic [2:0] rd);
    outs_t s;
    s = '0; s.alu_lo = 1'b1; s.gp_in = rd; s.gp_read = 1'b1;
    iphase(s);
  endtask
  // Expected cycles of one instruction: sf/so stall the first fetch / operand phase, nh halt cycles.
  task automatic issue(input logic [15:0] w, input logic [2:0] fl, input int sf, input int so,
                       input int nh, output int n);
    logic [3:0] opc, aop;
    logic [2:0] rd, rs;
    logic jmp;
    outs_t r, s, h;
    int n0;
    n0 = q.size();
    opc = w[15:12]; rd = w[11:9]; rs = w[8:6]; aop = w[3:0];
    jmp = opc == 4'd7 || opc == 4'd8;
    cur_fl = fl;
    r = '0; r.mem_rd = 1'b1;
    s = r; s.ir_hi = 1'b1; s.pc_inc = 1'b1; mphase(sf, r, s);
    s = r; s.ir_lo = 1'b1; s.pc_inc = 1'b1; mphase(0, r, s);
    s = '0; iphase(s);
    case (opc)
      4'd1: begin
        s = '0; s.gp_out = rs; s.gp_write = 1'b1; s.gp_in = rd; s.gp_read = 1'b1; iphase(s);
      end
      4'd2: begin
        s = r; s.pc_inc = 1'b1; s.gp_in = rd; s.gp_read = 1'b1; mphase(so, r, s);
      end
      4'd3: begin
        s = '0; s.gp_alu = rd; s.gp_out = rs; s.gp_write = 1'b1; s.alu_op = aop; s.latch_alu = 1'b1;
        iphase(s); wb(rd);
      end
      4'd4: begin
        s = r; s.pc_inc = 1'b1; s.gp_alu = rd; s.alu_op = aop; s.latch_alu = 1'b1;
        mphase(so, r, s); wb(rd);
      end
      4'd5, 4'd6, 4'd7, 4'd8: begin
        s = r; s.pc_inc = 1'b1; s.jr_hi = jmp; s.mar_hi = !jmp; mphase(0, r, s);
        s = r; s.pc_inc = 1'b1; s.jr_lo = jmp; s.mar_lo = !jmp; mphase(0, r, s);
        if (opc == 4'd5) begin
          h = r; h.addr_sel = 1'b1; s = h; s.gp_in = rd; s.gp_read = 1'b1; mphase(so, h, s);
        end else if (opc == 4'd6) begin
          h = '0; h.mem_wr = 1'b1; h.addr_sel = 1'b1; h.gp_out = rs; h.gp_write = 1'b1;
          mphase(so, h, h);
        end else begin
          s = '0; s.pc_set = opc == 4'd7 || fl[0]; iphase(s);
        end
      end
      4'd15: repeat (nh) begin
        s = '0; s.halted = 1'b1; iphase(s);
      end
      default: ;
    endcase
    n = q.size() - n0;
  endtask
  initial begin
    int n;
    reset = 1'b0; mem_ready = 1'b0; flags = 3'b000; cur_fl = 3'b000;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    put16(0, 16'h0000);
    put16(2, 16'h2600); mem[4] = 8'h5A;
    put16(5, 16'h3280);
    put16(7, 16'h1540);
    put16(9, 16'h4803); mem[11] = 8'h33;
    put16(12, 16'h5C00); put16(14, 16'h0100);
    put16(16, 16'h8000); put16(18, 16'h1234);
    put16(16'h1234, 16'h8000); put16(16'h1236, 16'h1234);
    put16(16'h1238, 16'h6140); put16(16'h123A, 16'hFEEF);
    put16(16'h123C, 16'h7000); put16(16'h123E, 16'h3000);
    put16(16'h3000, 16'h9000);
    put16(16'h3002, 16'hF000);
    rst(2);
    issue(16'h0000, 3'b000, 0, 0, 0, n); chk("lat_nop", n, 3);
    issue(16'h2600, 3'b000, 0, 0, 0, n); chk("lat_ldi", n, 4);
    issue(16'h3280, 3'b111, 0, 0, 0, n); chk("lat_alu", n, 5);
    issue(16'h1540, 3'b000, 0, 0, 0, n); chk("lat_mov", n, 4);
    issue(16'h4803, 3'b000, 0, 2, 0, n); chk("lat_alui_stall2", n, 7);
    issue(16'h5C00, 3'b001, 2, 1, 0, n); chk("lat_ld_stall3", n, 9);
    issue(16'h8000, 3'b001, 0, 0, 0, n); chk("lat_jz_taken", n, 6);
    issue(16'h8000, 3'b000, 0, 0, 0, n); chk("lat_jz_not", n, 6);
    issue(16'h6140, 3'b000, 0, 3, 0, n); chk("lat_st_stall3", n, 9);
    issue(16'h7000, 3'b000, 0, 0, 0, n); chk("lat_jmp", n, 6);
    issue(16'h9000, 3'b000, 0, 0, 0, n); chk("lat_op9", n, 3);
    issue(16'hF000, 3'b000, 0, 0, 4, n); chk("lat_halt", n, 7);
    q[q.size()-1].tag = 1;
    rst(2);
    issue(16'h0000, 3'b000, 0, 0, 0, n);
    q[q.size()-1].tag = 2;
    chk("pin_ldi_in", int'(q[8].exp.gp_in), 3);
    chk("pin_ldi_rd", int'(q[8].exp.gp_read), 1);
    chk("pin_alu_sel", int'({q[12].exp.gp_alu, q[12].exp.gp_out}), 6'o12);
    chk("pin_wb", int'({q[13].exp.alu_lo, q[13].exp.gp_in, q[13].exp.gp_read}), 5'b1_001_1);
    foreach (q[i]) begin
      @(negedge clock);
      reset = q[i].rst_n; mem_ready = q[i].ready; flags = q[i].fl;
      #2;
      tests++;
      if (act !== q[i].exp) begin
        fails++;
        $display("FAIL cycle%0d outputs: got %h want %h", i, act, q[i].exp);
      end
      if (act.pc_inc === 1'b1) pcinc++;
      if (q[i].tag == 1) begin
        chk("halt_pc", int'(pc), 16'h3004);
        chk("halt_ir", int'(ir), 16'hF000);
        chk("halt_mar", int'(mar), 16'hFEEF);
        chk("halt_jr", int'(jr), 16'h3000);
      end
      if (q[i].tag == 2) chk("restart_pc", int'(pc), 16'h0002);
    end
    chk("pc_increments", pcinc, 38);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
